sdram_page_writer: RTL and testbench
====================================

// Module: sdram_page_writer
// PURPOSE
//  Write-side feeder for sdramController. Gathers a valid/ready stream of 24-bit words into a
//  one-page buffer, then issues a single-cycle ctrlWr with the page start address and supplies
//  successive words on ctrlWrDataIn as the controller pulses ctrlWrIncAddress. It advances the
//  page address through a circular region of SDRAM and pads partial pages closed by inLast.
// PARAMETERS
//  PAGE_WORDS  256       words per SDRAM page (power of 2, equals the controller burst length)
//  BASE_ADDR   21'h0     first word address of the region (PAGE_WORDS aligned)
//  NUM_PAGES   8192      pages in the region before the address wraps to BASE_ADDR
//  PAD_WORD    24'h0     fill value for the unused tail of a page closed by inLast
// PORTS
//  sdramClk          in   1   single clock, shared with sdramController
//  rst               in   1   synchronous, active-high reset
//  inValid           in   1   upstream word valid
//  inReady           out  1   block accepts inData this cycle (valid & ready = transfer)
//  inData            in   24  upstream word
//  inLast            in   1   with a transfer: close the current page after this word
//  ctrlReady         in   1   controller is idle and SDRAM is initialised
//  ctrlWr            out  1   one-cycle page-write start strobe
//  ctrlWrAddress     out  21  page start word address, held stable from ctrlWr until DONE
//  ctrlWrIncAddress  in   1   controller consumed the current word and wants the next
//  ctrlWrDataIn      out  24  word currently offered to the controller
//  busy              out  1   high in any state except FILL with fillIdx==0
//  pageDone          out  1   one-cycle pulse when the last word of a page is consumed
//  pageCount         out  16  pages completed since reset (wraps modulo 2^16)
//  protoErr          out  1   sticky; set on a ctrlWrIncAddress outside STREAM
// BEHAVIOUR
//  Reset values: state=FILL, fillIdx=0, rdIdx=0, pageAddr=BASE_ADDR, inReady=1, ctrlWr=0,
//   ctrlWrDataIn=0, pageDone=0, pageCount=0, protoErr=0. A reset mid-page drops buffered
//   data. The controller is not reset by this block.
//  FILL: inReady=1. Each transfer writes buf[fillIdx] and increments fillIdx.
//   - Transfer with fillIdx==PAGE_WORDS-1: go to ARM.
//   - Transfer with inLast and a lower fillIdx: go to PAD.
//  PAD: inReady=0. Write PAD_WORD at fillIdx++ once per cycle. The cycle that writes index
//   PAGE_WORDS-1 goes to ARM.
//  ARM: inReady=0. Buffer read address is 0, so ctrlWrDataIn=buf[0] on the next edge.
//   Go to WAIT.
//  WAIT: when ctrlReady=1, drive ctrlWr=1 for exactly one cycle with ctrlWrAddress=pageAddr,
//   then go to STREAM. Stay in WAIT indefinitely while ctrlReady=0.
//  STREAM: ctrlWrDataIn holds buf[rdIdx] until a ctrlWrIncAddress pulse.
//   - On the pulse, rdIdx++ and ctrlWrDataIn=buf[rdIdx+1] on the next edge. The buffer read
//     port is addressed with the next index, so there is no bubble. Back-to-back pulses on
//     every cycle are supported.
//   - The pulse with rdIdx==PAGE_WORDS-1 pulses pageDone next cycle and increments pageCount.
//     It also advances pageAddr by PAGE_WORDS, wrapping to BASE_ADDR after NUM_PAGES pages.
//     It clears fillIdx and rdIdx and returns to FILL. inReady=1 one cycle after pageDone.
//  ctrlWrIncAddress in FILL/PAD/ARM/WAIT: ignored for data and sets protoErr.
//  A simultaneous transfer and state exit is impossible because inReady is low outside FILL.
//  Widths: fillIdx and rdIdx are log2(PAGE_WORDS)+1 bits. pageAddr arithmetic is 21-bit
//   unsigned, with the wrap compared against BASE_ADDR+NUM_PAGES*PAGE_WORDS.
// STRUCTURE
//  Shared package sdram_pkg:
//   - SDRAM_ADDR_W=21, SDRAM_WORD_W=24
//   - state enum {FILL,PAD,ARM,WAIT,STREAM}
//   - the page-address wrap function
//  Sub-module sdram_page_buffer: simple dual-port RAM, PAGE_WORDS x 24, one write port and
//   one registered read port, inferred as BSRAM.
//  FSM, counters and address logic stay in sdram_page_writer.
// TESTING
//  1 Reset, then stream 256 words 0..255, ctrlReady=1, controller model pulses inc every cycle
//    -> one ctrlWr with addr 0; data seen 0..255 in order; pageDone once; pageCount=1.
//  2 Send 3 words A,B,C then inLast -> ctrlWrDataIn shows A,B,C, then 253 x PAD_WORD;
//    the next page uses addr 256.
//  3 Hold ctrlReady=0 for 50 cycles after the page is full -> ctrlWr stays 0, inReady=0,
//    no data lost; ctrlWr fires one cycle after ctrlReady rises.
//  4 Random gaps of 0-3 cycles between inc pulses -> ctrlWrDataIn is stable between pulses
//    and the sequence is intact.
//  5 NUM_PAGES=2, write 3 pages -> addresses 0, 256, 0; pageCount=3.
//  6 Inc pulse during FILL -> protoErr=1, held until rst; assert rst mid-STREAM ->
//    all outputs return to reset values next cycle.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM write path.
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 21;
   localparam int SDRAM_WORD_W = 24;

   typedef enum logic [2:0] {
      FILL,
      PAD,
      ARM,
      WAIT,
      STREAM
   } wr_state_e;

   // Advance to the next page, folding back to base once the region end is reached.
   function automatic logic [SDRAM_ADDR_W-1:0] next_page_addr(
      input logic [SDRAM_ADDR_W-1:0] addr,
      input logic [SDRAM_ADDR_W-1:0] base,
      input logic [SDRAM_ADDR_W-1:0] region_end,
      input logic [SDRAM_ADDR_W-1:0] page_words
   );
      logic [SDRAM_ADDR_W-1:0] nxt;
      nxt = addr + page_words;
      return (nxt == region_end) ? base : nxt;
   endfunction

endpackage

// File: rtl/sdram_page_buffer.sv
// One-page simple dual-port buffer: one write port, one registered read port.
module sdram_page_buffer
   import sdram_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [SDRAM_WORD_W-1:0] wr_data,
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_addr,
   output logic [SDRAM_WORD_W-1:0] rd_data
);

   logic [SDRAM_WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Output register keeps its value when not enabled, so the offered word holds steady.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sdram_page_writer.sv
// Gathers a word stream into a page buffer and feeds it to sdramController as one page write.
module sdram_page_writer
   import sdram_pkg::*;
#(
   parameter int                       PAGE_WORDS = 256,
   parameter logic [SDRAM_ADDR_W-1:0]  BASE_ADDR  = 21'h0,
   parameter int                       NUM_PAGES  = 8192,
   parameter logic [SDRAM_WORD_W-1:0]  PAD_WORD   = 24'h0
) (
   input  logic                    sdramClk,
   input  logic                    rst,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [SDRAM_WORD_W-1:0] inData,
   input  logic                    inLast,
   input  logic                    ctrlReady,
   output logic                    ctrlWr,
   output logic [SDRAM_ADDR_W-1:0] ctrlWrAddress,
   input  logic                    ctrlWrIncAddress,
   output logic [SDRAM_WORD_W-1:0] ctrlWrDataIn,
   output logic                    busy,
   output logic                    pageDone,
   output logic [15:0]             pageCount,
   output logic                    protoErr
);

   localparam int AW    = $clog2(PAGE_WORDS);
   localparam int IDX_W = AW + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);
   localparam logic [SDRAM_ADDR_W-1:0] REGION_END =
      SDRAM_ADDR_W'(64'(BASE_ADDR) + 64'(NUM_PAGES) * 64'(PAGE_WORDS));
   localparam logic [SDRAM_ADDR_W-1:0] PAGE_STEP = SDRAM_ADDR_W'(PAGE_WORDS);

   wr_state_e               state, state_nxt;
   logic [IDX_W-1:0]        fill_idx, rd_idx, rd_idx_inc;
   logic [SDRAM_ADDR_W-1:0] page_addr;
   logic                    in_ready_q, ctrl_wr_q, page_done_q, proto_err_q;
   logic [15:0]             page_count_q;

   logic                    transfer, last_inc;
   logic                    wr_en, rd_en;
   logic [SDRAM_WORD_W-1:0] wr_data;
   logic [AW-1:0]           rd_addr;

   assign transfer   = inValid & in_ready_q;
   assign rd_idx_inc = rd_idx + 1'b1;

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_data   = inData;
      rd_en     = 1'b0;
      rd_addr   = rd_idx[AW-1:0];
      last_inc  = 1'b0;
      case (state)
         FILL: begin
            if (transfer) begin
               wr_en = 1'b1;
               if (fill_idx == LAST_IDX) state_nxt = ARM;
               else if (inLast)          state_nxt = PAD;
            end
         end
         PAD: begin
            wr_en   = 1'b1;
            wr_data = PAD_WORD;
            if (fill_idx == LAST_IDX) state_nxt = ARM;
         end
         ARM: begin
            rd_en     = 1'b1;
            rd_addr   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (ctrlReady) state_nxt = STREAM;
         end
         STREAM: begin
            rd_en = 1'b1;
            // Look ahead one index on a pulse so the next word lands with no bubble.
            if (ctrlWrIncAddress) begin
               rd_addr = rd_idx_inc[AW-1:0];
               if (rd_idx == LAST_IDX) begin
                  last_inc  = 1'b1;
                  state_nxt = FILL;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge sdramClk) begin
      if (rst) begin
         state        <= FILL;
         fill_idx     <= '0;
         rd_idx       <= '0;
         page_addr    <= BASE_ADDR;
         in_ready_q   <= 1'b1;
         ctrl_wr_q    <= 1'b0;
         page_done_q  <= 1'b0;
         page_count_q <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         // Upstream reopens one cycle after the page-done pulse.
         in_ready_q  <= (state_nxt == FILL) && (state != STREAM);
         ctrl_wr_q   <= (state == WAIT) && ctrlReady;
         page_done_q <= last_inc;
         if (wr_en) fill_idx <= fill_idx + 1'b1;
         if (state == STREAM && ctrlWrIncAddress) rd_idx <= rd_idx_inc;
         if (last_inc) begin
            fill_idx     <= '0;
            rd_idx       <= '0;
            page_count_q <= page_count_q + 16'd1;
            page_addr    <= next_page_addr(page_addr, BASE_ADDR, REGION_END, PAGE_STEP);
         end
         if (ctrlWrIncAddress && state != STREAM) proto_err_q <= 1'b1;
      end
   end

   sdram_page_buffer #(
      .DEPTH (PAGE_WORDS)
   ) u_buf (
      .clk     (sdramClk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (fill_idx[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ctrlWrDataIn)
   );

   assign inReady       = in_ready_q;
   assign ctrlWr        = ctrl_wr_q;
   assign ctrlWrAddress = page_addr;
   assign busy          = !(state == FILL && fill_idx == '0);
   assign pageDone      = page_done_q;
   assign pageCount     = page_count_q;
   assign protoErr      = proto_err_q;

endmodule

// File: tb/tb_sdram_page_writer.sv
// Directed bench for sdram_page_writer with a page-level reference model and a controller model.
module tb_sdram_page_writer;

   localparam int          PW   = 256;
   localparam int          NP   = 2;
   localparam logic [20:0] BASE = 21'h0;
   localparam logic [23:0] PADW = 24'h5A5A5A;

   logic        sdramClk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0, inLast = 1'b0, ctrlReady = 1'b0;
   logic [23:0] inData = '0;
   logic        ctl_inc = 1'b0, force_inc = 1'b0;
   logic        inReady, ctrlWr, ctrlWrIncAddress, busy, pageDone, protoErr;
   logic [20:0] ctrlWrAddress;
   logic [23:0] ctrlWrDataIn;
   logic [15:0] pageCount;

   assign ctrlWrIncAddress = ctl_inc | force_inc;
   always #5 sdramClk = ~sdramClk;

   sdram_page_writer #(
      .PAGE_WORDS (PW),
      .BASE_ADDR  (BASE),
      .NUM_PAGES  (NP),
      .PAD_WORD   (PADW)
   ) dut (
      .sdramClk         (sdramClk),
      .rst              (rst),
      .inValid          (inValid),
      .inReady          (inReady),
      .inData           (inData),
      .inLast           (inLast),
      .ctrlReady        (ctrlReady),
      .ctrlWr           (ctrlWr),
      .ctrlWrAddress    (ctrlWrAddress),
      .ctrlWrIncAddress (ctrlWrIncAddress),
      .ctrlWrDataIn     (ctrlWrDataIn),
      .busy             (busy),
      .pageDone         (pageDone),
      .pageCount        (pageCount),
      .protoErr         (protoErr)
   );

   int n_pass = 0, n_tot = 0;
   bit gap_mode = 1'b0;

   // Reference model: pages as word lists, plus what the controller observed.
   logic [23:0] m_words[$], m_fill[$], seen[$];
   logic [20:0] m_addrs[$];
   int          m_rd = 0, m_count = 0, page_no = 0, wr_cnt = 0;
   bit          m_streaming = 0, m_proto = 0, done_due = 0, prev_ready = 0;
   logic [20:0] last_wr_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] seen_at(input int i);
      return (seen.size() > i) ? {8'h0, seen[i]} : 32'hDEAD_BEEF;
   endfunction

   initial begin
      forever begin
         @(negedge sdramClk);
         if (rst) begin
            m_words.delete(); m_fill.delete(); m_addrs.delete();
            m_rd = 0; m_count = 0; page_no = 0;
            m_streaming = 0; m_proto = 0; done_due = 0; prev_ready = 0;
         end else begin
            chk("in_ready", inReady, !(m_addrs.size() > 0 || done_due));
            chk("busy", busy, (m_addrs.size() > 0 || m_fill.size() > 0));
            chk("page_done", pageDone, done_due);
            chk("page_count", pageCount, m_count[15:0]);
            chk("proto_err", protoErr, m_proto);
            done_due = 0;
            if (ctrlWr) begin
               chk("wr_legal", (m_addrs.size() > 0 && !m_streaming && prev_ready), 1);
               if (m_addrs.size() > 0) chk("wr_addr", ctrlWrAddress, m_addrs[0]);
               wr_cnt++;
               last_wr_addr = ctrlWrAddress;
               seen.delete();
               m_streaming = (m_addrs.size() > 0);
               m_rd = 0;
            end
            if (m_streaming) begin
               chk("wr_data", ctrlWrDataIn, m_words[m_rd]);
               chk("addr_hold", ctrlWrAddress, m_addrs[0]);
            end
            if (ctrlWrIncAddress) begin
               if (m_streaming) begin
                  seen.push_back(ctrlWrDataIn);
                  m_rd++;
                  if (m_rd == PW) begin
                     for (int i = 0; i < PW; i++) void'(m_words.pop_front());
                     void'(m_addrs.pop_front());
                     m_streaming = 0;
                     m_count++;
                     done_due = 1;
                  end
               end else begin
                  m_proto = 1;
               end
            end
            if (inValid && inReady) begin
               m_fill.push_back(inData);
               if (inLast || m_fill.size() == PW) begin
                  while (m_fill.size() < PW) m_fill.push_back(PADW);
                  for (int i = 0; i < PW; i++) m_words.push_back(m_fill[i]);
                  m_addrs.push_back(BASE + 21'((page_no % NP) * PW));
                  page_no++;
                  m_fill.delete();
               end
            end
            prev_ready = ctrlReady;
         end
      end
   end

   // Controller model: after each ctrlWr, request PW words, optionally with idle gaps.
   initial begin
      int k, g;
      forever begin
         @(negedge sdramClk);
         if (ctrlWr && !rst) begin
            k = 0;
            g = gap_mode ? int'($urandom_range(0, 3)) : 0;
            while (k < PW) begin
               @(posedge sdramClk); #2;
               if (rst) begin ctl_inc = 1'b0; break; end
               if (g > 0) begin
                  ctl_inc = 1'b0; g--;
               end else begin
                  ctl_inc = 1'b1; k++;
                  g = gap_mode ? int'($urandom_range(0, 3)) : 0;
               end
            end
            if (!rst) begin @(posedge sdramClk); #2; ctl_inc = 1'b0; end
         end
      end
   end

   task automatic send(input logic [23:0] d, input logic l);
      int t = 0;
      inValid = 1'b1; inData = d; inLast = l;
      @(negedge sdramClk);
      while (!inReady && t < 4000) begin @(negedge sdramClk); t++; end
      if (t >= 4000) chk("send_timeout", inReady, 1);
      @(posedge sdramClk); #1;
      inValid = 1'b0; inLast = 1'b0;
   endtask

   task automatic wait_count(input int n);
      int t = 0;
      while (pageCount != 16'(n) && t < 4000) begin @(negedge sdramClk); t++; end
      if (t >= 4000) chk("page_timeout", pageCount, 16'(n));
      @(posedge sdramClk); #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"}, inReady, 1);
      chk({tag, "_ctrl_wr"}, ctrlWr, 0);
      chk({tag, "_wr_data"}, ctrlWrDataIn, 0);
      chk({tag, "_wr_addr"}, ctrlWrAddress, 0);
      chk({tag, "_page_done"}, pageDone, 0);
      chk({tag, "_page_count"}, pageCount, 0);
      chk({tag, "_proto_err"}, protoErr, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic [23:0] w0, d;
      int t;
      rst = 1'b1;
      repeat (3) @(posedge sdramClk);
      #1;
      @(negedge sdramClk);
      chk_reset_values("reset");
      @(posedge sdramClk); #1;
      rst = 1'b0;

      // Full page 0..255, inc every cycle.
      ctrlReady = 1'b1; gap_mode = 1'b0;
      for (int i = 0; i < PW; i++) send(24'(i), 1'b0);
      wait_count(1);
      chk("t1_wr_cnt", wr_cnt, 1);
      chk("t1_addr", last_wr_addr, 21'h0);
      chk("t1_len", seen.size(), 256);
      chk("t1_w0", seen_at(0), 32'h0);
      chk("t1_w128", seen_at(128), 32'h80);
      chk("t1_w255", seen_at(255), 32'hFF);
      chk("t1_count", pageCount, 1);

      // Short page closed by inLast.
      send(24'hA0A0A0, 1'b0);
      send(24'hB1B1B1, 1'b0);
      send(24'hC2C2C2, 1'b1);
      wait_count(2);
      chk("t2_addr", last_wr_addr, 21'd256);
      chk("t2_len", seen.size(), 256);
      chk("t2_w0", seen_at(0), 32'hA0A0A0);
      chk("t2_w1", seen_at(1), 32'hB1B1B1);
      chk("t2_w2", seen_at(2), 32'hC2C2C2);
      chk("t2_pad3", seen_at(3), 32'h5A5A5A);
      chk("t2_pad255", seen_at(255), 32'h5A5A5A);

      // Controller not ready for 50 cycles; region wraps on this third page.
      ctrlReady = 1'b0;
      for (int i = 0; i < PW; i++) send(24'h100000 + 24'(i), 1'b0);
      repeat (50) @(negedge sdramClk);
      chk("t3_no_wr", wr_cnt, 2);
      chk("t3_in_ready", inReady, 0);
      chk("t3_busy", busy, 1);
      @(posedge sdramClk); #1;
      ctrlReady = 1'b1;
      @(negedge sdramClk);
      chk("t3_wr_not_yet", ctrlWr, 0);
      @(negedge sdramClk);
      chk("t3_wr_fires", ctrlWr, 1);
      wait_count(3);
      chk("t3_wrap_addr", last_wr_addr, 21'h0);
      chk("t3_count", pageCount, 3);
      chk("t3_w0", seen_at(0), 32'h100000);
      chk("t3_w255", seen_at(255), 32'h1000FF);

      // Random gaps between inc pulses.
      gap_mode = 1'b1;
      w0 = 24'($urandom);
      send(w0, 1'b0);
      for (int i = 1; i < PW; i++) begin
         d = 24'($urandom);
         send(d, 1'b0);
      end
      wait_count(4);
      chk("t4_addr", last_wr_addr, 21'd256);
      chk("t4_len", seen.size(), 256);
      chk("t4_w0", seen_at(0), {8'h0, w0});

      // Protocol error in FILL, then reset mid-stream.
      gap_mode = 1'b0;
      @(posedge sdramClk); #1; force_inc = 1'b1;
      @(posedge sdramClk); #1; force_inc = 1'b0;
      @(negedge sdramClk);
      chk("t6_proto_set", protoErr, 1);
      repeat (5) @(negedge sdramClk);
      chk("t6_proto_sticky", protoErr, 1);
      @(posedge sdramClk); #1;
      for (int i = 0; i < PW; i++) send(24'h200000 + 24'(i), 1'b0);
      t = 0;
      while (!(wr_cnt == 5 && seen.size() >= 20) && t < 4000) begin
         @(negedge sdramClk); t++;
      end
      if (t >= 4000) chk("t6_stream_timeout", wr_cnt, 5);
      @(posedge sdramClk); #1;
      rst = 1'b1;
      @(negedge sdramClk);
      @(negedge sdramClk);
      chk_reset_values("midrst");
      @(posedge sdramClk); #1;
      rst = 1'b0;

      // One-word page after reset: buffered data was dropped, address restarts.
      send(24'h3C3C3C, 1'b1);
      wait_count(1);
      chk("t6_addr", last_wr_addr, 21'h0);
      chk("t6_count", pageCount, 1);
      chk("t6_w0", seen_at(0), 32'h3C3C3C);
      chk("t6_pad1", seen_at(1), 32'h5A5A5A);
      chk("t6_pad255", seen_at(255), 32'h5A5A5A);
      chk("t6_proto_clear", protoErr, 0);

      repeat (5) @(negedge sdramClk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
      $fatal(1);
   end

endmodule
